// File: rtl/smm_seq_ctrl.sv
// Bit-serial sign-magnitude MAC sequencer: feeds one weight magnitude bit per cycle to an external multiplier.
// Optional zero-bit skipping (popcount cycles per pair) is enabled by defining SMM_ZERO_SKIP_EN.
module smm_seq_ctrl #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_act,
  input  logic [7:0]       in_weight,
  input  logic             in_last,
  output logic [7:0]       smm_act,
  output logic             smm_weight_bit,
  output logic             smm_weight_sign,
  input  logic [7:0]       smm_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [7:0]       act_q, act_d;
  logic             sign_q, sign_d;
  logic [6:0]       mag_q, mag_d;
  logic             last_q, last_d;
  logic [2:0]       idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic             accept;
  logic             zero_mag;
  logic             run_end;
  logic [2:0]       idx_first;
  logic [2:0]       idx_next;
  logic [ACC_W-1:0] addend;

  assign accept = in_valid && (state_q == IDLE);

`ifdef SMM_ZERO_SKIP_EN
  // Lowest set bit of m at or above position from; bit 3 of the result flags a hit.
  function automatic logic [3:0] first_set(input logic [6:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 6; i >= 0; i--) begin
      if (i >= int'(from) && m[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  logic [3:0] hit_first;
  logic [3:0] hit_next;

  assign hit_first = first_set(in_weight[6:0], 4'd0);
  assign hit_next  = first_set(mag_q, {1'b0, idx_q} + 4'd1);
  assign zero_mag  = ~hit_first[3];
  assign idx_first = hit_first[2:0];
  assign run_end   = ~hit_next[3];
  assign idx_next  = hit_next[2:0];
`else
  assign zero_mag  = 1'b0;
  assign idx_first = 3'd0;
  assign run_end   = (idx_q == 3'd6);
  assign idx_next  = idx_q + 3'd1;
`endif

  // Multiplier output is trusted as-is, including its -128 wrap.
  assign addend = {{(ACC_W-8){smm_product[7]}}, smm_product} << idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) begin
        if (zero_mag) state_d = in_last ? DONE : IDLE;
        else          state_d = RUN;
      end
      RUN:  if (run_end) state_d = last_q ? DONE : IDLE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    smm_weight_bit = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      RUN:     smm_weight_bit = mag_q[idx_q];
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    act_d  = act_q;
    sign_d = sign_q;
    mag_d  = mag_q;
    last_d = last_q;
    idx_d  = idx_q;
    acc_d  = acc_q;
    if (accept) begin
      act_d  = in_act;
      sign_d = in_weight[7];
      mag_d  = in_weight[6:0];
      last_d = in_last;
      idx_d  = idx_first;
    end else if (state_q == RUN) begin
      acc_d = acc_q + addend;
      idx_d = idx_next;
    end else if (state_q == DONE && out_ready) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= 8'd0;
      sign_q <= 1'b0;
      mag_q  <= 7'd0;
      last_q <= 1'b0;
      idx_q  <= 3'd0;
      acc_q  <= '0;
    end else begin
      act_q  <= act_d;
      sign_q <= sign_d;
      mag_q  <= mag_d;
      last_q <= last_d;
      idx_q  <= idx_d;
      acc_q  <= acc_d;
    end
  end

  assign smm_act         = act_q;
  assign smm_weight_sign = sign_q;
  assign out_acc         = acc_q;

endmodule
